// File: rtl/forward_hazard_unit.sv
// ---------------------------------------------------------------------------
// forward_hazard_unit
//
// Operand forwarding and RAW hazard control for the ID->EX boundary.
// Each EX operand (A from rs, B from rt) can be taken from any of N_STAGES
// downstream write-back sources. Stage 0 is the youngest (EX) and wins over
// older stages. If the winning source has no data yet (load-use), the unit
// stalls the front end and injects a bubble into EX. A watchdog sets a sticky
// error flag when a stall lasts MAX_STALL consecutive cycles.
//
// Optional feature macro: HAZARD_STATS_EN
//   When defined, adds two saturating 32-bit counters: stall cycles and
//   forwarding events.
//
// Ports
//   i_clock         clock
//   i_reset         synchronous active-high reset
//   i_valid         pipeline advance enable
//   i_rs, i_rt      source register addresses of the ID instruction
//   i_use_rs        operand A reads rs
//   i_use_rt        operand B reads rt
//   i_rd            per-stage destination address, stage k at [k*NB_REG_ADDR +: NB_REG_ADDR]
//   i_we            per-stage register-file write enable
//   i_ready         per-stage result valid this cycle
//   i_data          per-stage result, stage k at [k*NB_REG +: NB_REG]
//   o_stall         combinational: freeze PC and IF/ID
//   o_bubble        registered: EX receives a NOP
//   o_mux_a/b       registered: use forwarded operand instead of regfile
//   o_data_a/b      registered forwarded operands
//   o_err           sticky: stall lasted MAX_STALL cycles
//   o_stall_cycles  (HAZARD_STATS_EN) cycles with o_stall asserted
//   o_fwd_events    (HAZARD_STATS_EN) advancing cycles with a forwarded operand
// ---------------------------------------------------------------------------
module forward_hazard_unit #(
    parameter int NB_REG      = 32,
    parameter int NB_REG_ADDR = 5,
    parameter int N_STAGES    = 3,
    parameter int MAX_STALL   = 8
) (
    input  logic                            i_clock,
    input  logic                            i_reset,
    input  logic                            i_valid,
    input  logic [NB_REG_ADDR-1:0]          i_rs,
    input  logic [NB_REG_ADDR-1:0]          i_rt,
    input  logic                            i_use_rs,
    input  logic                            i_use_rt,
    input  logic [N_STAGES*NB_REG_ADDR-1:0] i_rd,
    input  logic [N_STAGES-1:0]             i_we,
    input  logic [N_STAGES-1:0]             i_ready,
    input  logic [N_STAGES*NB_REG-1:0]      i_data,
    output logic                            o_stall,
    output logic                            o_bubble,
    output logic                            o_mux_a,
    output logic                            o_mux_b,
    output logic [NB_REG-1:0]               o_data_a,
    output logic [NB_REG-1:0]               o_data_b,
    output logic                            o_err
`ifdef HAZARD_STATS_EN
    ,
    output logic [31:0]                     o_stall_cycles,
    output logic [31:0]                     o_fwd_events
`endif
);

    localparam int CNT_W = $clog2(MAX_STALL + 1);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_STALL);

    typedef enum logic {
        RUN   = 1'b0,
        STALL = 1'b1
    } state_e;

    // -----------------------------------------------------------------------
    // Winner selection (combinational)
    // -----------------------------------------------------------------------
    logic              found_a, found_b;
    logic              ready_a, ready_b;
    logic [NB_REG-1:0] sel_a, sel_b;
    logic              hazard;

    // NOTE: every signal written in this block gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        found_a = 1'b0;
        found_b = 1'b0;
        ready_a = 1'b1;
        ready_b = 1'b1;
        sel_a   = '0;
        sel_b   = '0;
        // Walk from oldest to youngest so a younger match overwrites an
        // older one; the survivor is the lowest matching index. Register $0
        // is excluded so it never forwards and never stalls.
        for (int k = N_STAGES - 1; k >= 0; k--) begin
            if (i_we[k] && i_use_rs && (i_rs != '0) &&
                (i_rd[k*NB_REG_ADDR +: NB_REG_ADDR] == i_rs)) begin
                found_a = 1'b1;
                ready_a = i_ready[k];
                sel_a   = i_data[k*NB_REG +: NB_REG];
            end
            if (i_we[k] && i_use_rt && (i_rt != '0) &&
                (i_rd[k*NB_REG_ADDR +: NB_REG_ADDR] == i_rt)) begin
                found_b = 1'b1;
                ready_b = i_ready[k];
                sel_b   = i_data[k*NB_REG +: NB_REG];
            end
        end
        hazard = (found_a && !ready_a) || (found_b && !ready_b);
    end

    // Stall must reach the PC/IF-ID enables in the same cycle.
    assign o_stall = hazard && i_valid;

    // -----------------------------------------------------------------------
    // EX-side registered outputs
    // -----------------------------------------------------------------------
    logic              mux_a_q, mux_a_d;
    logic              mux_b_q, mux_b_d;
    logic [NB_REG-1:0] data_a_q, data_a_d;
    logic [NB_REG-1:0] data_b_q, data_b_d;
    logic              bubble_q, bubble_d;

    always_comb begin
        mux_a_d  = mux_a_q;
        mux_b_d  = mux_b_q;
        data_a_d = data_a_q;
        data_b_d = data_b_q;
        bubble_d = bubble_q;
        if (i_valid) begin
            if (hazard) begin
                // Load-use: EX gets a NOP, no operand is forwarded.
                mux_a_d  = 1'b0;
                mux_b_d  = 1'b0;
                data_a_d = '0;
                data_b_d = '0;
                bubble_d = 1'b1;
            end else begin
                mux_a_d  = found_a;
                mux_b_d  = found_b;
                data_a_d = sel_a;
                data_b_d = sel_b;
                bubble_d = 1'b0;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            mux_a_q  <= 1'b0;
            mux_b_q  <= 1'b0;
            data_a_q <= '0;
            data_b_q <= '0;
            bubble_q <= 1'b0;
        end else begin
            mux_a_q  <= mux_a_d;
            mux_b_q  <= mux_b_d;
            data_a_q <= data_a_d;
            data_b_q <= data_b_d;
            bubble_q <= bubble_d;
        end
    end

    assign o_mux_a  = mux_a_q;
    assign o_mux_b  = mux_b_q;
    assign o_data_a = data_a_q;
    assign o_data_b = data_b_q;
    assign o_bubble = bubble_q;

    // -----------------------------------------------------------------------
    // Stall watchdog FSM
    // -----------------------------------------------------------------------
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            RUN: begin
                cnt_d = '0;
                if (o_stall) begin
                    state_d = STALL;
                    cnt_d   = CNT_W'(1);
                end
            end
            STALL: begin
                if (!o_stall) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end else if (cnt_q != MAX_CNT) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = RUN;
                cnt_d   = '0;
            end
        endcase
        // Sticky: once the count reaches the limit, only reset clears it.
        err_d = err_q || (cnt_d == MAX_CNT);
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q <= RUN;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    assign o_err = err_q;

`ifdef HAZARD_STATS_EN
    // -----------------------------------------------------------------------
    // Optional statistics counters (saturating)
    // -----------------------------------------------------------------------
    logic [31:0] stall_cycles_q, stall_cycles_d;
    logic [31:0] fwd_events_q, fwd_events_d;

    always_comb begin
        stall_cycles_d = stall_cycles_q;
        fwd_events_d   = fwd_events_q;
        if (o_stall && (stall_cycles_q != '1)) begin
            stall_cycles_d = stall_cycles_q + 32'd1;
        end
        // At most one event per cycle, even if both operands forward.
        if (i_valid && !hazard && (found_a || found_b) && (fwd_events_q != '1)) begin
            fwd_events_d = fwd_events_q + 32'd1;
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            stall_cycles_q <= '0;
            fwd_events_q   <= '0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
            fwd_events_q   <= fwd_events_d;
        end
    end

    assign o_stall_cycles = stall_cycles_q;
    assign o_fwd_events   = fwd_events_q;
`endif

endmodule
